// File: rtl/register_file_pkg.sv
// register_file_pkg: shared widths and types for the register file slice
package register_file_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_REGS = 32;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/register_file_read_port.sv
// regfile_read_port: combinational read mux with zero register and optional write-first bypass (WRITE_BYPASS_EN)
module regfile_read_port
  import register_file_pkg::*;
(
  input  data_t     regs [NUM_REGS],
  input  reg_addr_t addr,
`ifdef WRITE_BYPASS_EN
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  data_t     wdata,
`endif
  output data_t     dout
);
`ifdef WRITE_BYPASS_EN
  // the zero check comes first so a write aimed at reg 0 is never forwarded
  always_comb dout = (addr == '0) ? '0 : (we && !rst && addr == waddr) ? wdata : regs[addr];
`else
  always_comb dout = (addr == '0) ? '0 : regs[addr];
`endif
endmodule

// File: rtl/register_file.sv
// register_file: 32x32 register file, three combinational reads, one write, registered copies of ports 1/2 (WRITE_BYPASS_EN: write-first reads)
module register_file
  import register_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  output data_t     dout1,
  output data_t     dout2,
  output data_t     dout3,
  input  reg_addr_t addr1,
  input  reg_addr_t addr2,
  input  reg_addr_t addr3,
  input  data_t     din,
  output data_t     dout1_out,
  output data_t     dout2_out,
  input  logic      We
);
  data_t regs [NUM_REGS];
  always_ff @(posedge clk) begin
    if (rst) begin
      regs <= '{default: '0};
      dout1_out <= '0;
      dout2_out <= '0;
    end else begin
      if (We && addr3 != '0) regs[addr3] <= din;
      dout1_out <= dout1;
      dout2_out <= dout2;
    end
  end
  regfile_read_port u_rd1 (
    .regs(regs), .addr(addr1),
`ifdef WRITE_BYPASS_EN
    .rst(rst), .we(We), .waddr(addr3), .wdata(din),
`endif
    .dout(dout1)
  );
  regfile_read_port u_rd2 (
    .regs(regs), .addr(addr2),
`ifdef WRITE_BYPASS_EN
    .rst(rst), .we(We), .waddr(addr3), .wdata(din),
`endif
    .dout(dout2)
  );
  regfile_read_port u_rd3 (
    .regs(regs), .addr(addr3),
`ifdef WRITE_BYPASS_EN
    .rst(rst), .we(We), .waddr(addr3), .wdata(din),
`endif
    .dout(dout3)
  );
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed vector table plus randomized run against an array model
module tb_register_file;
  import register_file_pkg::*;
`ifdef WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst, We;
  reg_addr_t addr1, addr2, addr3;
  data_t din, dout1, dout2, dout3, dout1_out, dout2_out;
  int checks = 0, errors = 0;
  data_t model [NUM_REGS];
  data_t e1, e2, e3, q1, q2;

  always #5 clk = ~clk;

  register_file dut (
    .clk(clk), .rst(rst), .dout1(dout1), .dout2(dout2), .dout3(dout3),
    .addr1(addr1), .addr2(addr2), .addr3(addr3), .din(din),
    .dout1_out(dout1_out), .dout2_out(dout2_out), .We(We)
  );

  typedef struct {
    logic r, w, chk;
    reg_addr_t a1, a2, a3;
    data_t d, x1, x2, x3, y1, y2;
  } vec_t;
  vec_t tbl [13];

  task automatic check(input string name, input data_t act, input data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic w, input reg_addr_t a1, input reg_addr_t a2,
                       input reg_addr_t a3, input data_t d);
    rst = r; We = w; addr1 = a1; addr2 = a2; addr3 = a3; din = d;
  endtask

  function automatic data_t rd(input reg_addr_t a);
    if (a == 0) return '0;
    if (BYP && We && !rst && a == addr3) return din;
    return model[a];
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    end else if (We && addr3 != 0) model[addr3] = din;
  endtask

  function automatic data_t pick(input data_t rf, input data_t wf);
    return BYP ? wf : rf;
  endfunction

  function automatic vec_t mk(input logic r, input logic w, input logic c, input reg_addr_t a1,
                              input reg_addr_t a2, input reg_addr_t a3, input data_t d,
                              input data_t x1, input data_t x2, input data_t x3,
                              input data_t y1, input data_t y2);
    vec_t v;
    v.r = r; v.w = w; v.chk = c; v.a1 = a1; v.a2 = a2; v.a3 = a3; v.d = d;
    v.x1 = x1; v.x2 = x2; v.x3 = x3; v.y1 = y1; v.y2 = y2;
    return v;
  endfunction

  initial begin
    tbl[0]  = mk(1, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 1, 1, 2, 3, 0, 0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 1, 1, 3, 0, 3, 32'hAA55FFF0, pick(0, 32'hAA55FFF0), 0, pick(0, 32'hAA55FFF0),
                 pick(0, 32'hAA55FFF0), 0);
    tbl[3]  = mk(0, 0, 1, 3, 3, 3, 0, 32'hAA55FFF0, 32'hAA55FFF0, 32'hAA55FFF0, 32'hAA55FFF0, 32'hAA55FFF0);
    tbl[4]  = mk(0, 1, 1, 0, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 1, 0, 3, 0, 0, 0, 32'hAA55FFF0, 0, 0, 32'hAA55FFF0);
    tbl[6]  = mk(0, 0, 1, 5, 5, 5, 32'h12345678, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 0, 1, 5, 5, 5, 0, 0, 0, 0, 0, 0);
    tbl[8]  = mk(0, 1, 1, 0, 0, 7, 32'h11111111, 0, 0, pick(0, 32'h11111111), 0, 0);
    tbl[9]  = mk(0, 1, 1, 7, 7, 7, 32'h22222222, pick(32'h11111111, 32'h22222222),
                 pick(32'h11111111, 32'h22222222), pick(32'h11111111, 32'h22222222),
                 pick(32'h11111111, 32'h22222222), pick(32'h11111111, 32'h22222222));
    tbl[10] = mk(0, 0, 1, 7, 7, 7, 0, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222, 32'h22222222);
    tbl[11] = mk(1, 1, 1, 7, 4, 4, 32'hDEADBEEF, 32'h22222222, 0, 0, 0, 0);
    tbl[12] = mk(0, 0, 1, 4, 7, 4, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].r, tbl[i].w, tbl[i].a1, tbl[i].a2, tbl[i].a3, tbl[i].d);
      @(negedge clk);
      if (tbl[i].chk) begin
        check($sformatf("vec%0d_dout1", i), dout1, tbl[i].x1);
        check($sformatf("vec%0d_dout2", i), dout2, tbl[i].x2);
        check($sformatf("vec%0d_dout3", i), dout3, tbl[i].x3);
      end
      @(posedge clk);
      model_edge();
      #1;
      check($sformatf("vec%0d_dout1_out", i), dout1_out, tbl[i].y1);
      check($sformatf("vec%0d_dout2_out", i), dout2_out, tbl[i].y2);
    end
    // random traffic, addresses biased to a small window so ports collide often
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 31) == 0, $urandom_range(0, 1) == 1,
            reg_addr_t'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)),
            reg_addr_t'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)),
            reg_addr_t'($urandom_range(0, 1) ? $urandom_range(0, 3) : $urandom_range(0, 31)),
            data_t'($urandom));
      @(negedge clk);
      e1 = rd(addr1); e2 = rd(addr2); e3 = rd(addr3);
      check("rnd_dout1", dout1, e1);
      check("rnd_dout2", dout2, e2);
      check("rnd_dout3", dout3, e3);
      q1 = rst ? '0 : e1;
      q2 = rst ? '0 : e2;
      @(posedge clk);
      model_edge();
      #1;
      check("rnd_dout1_out", dout1_out, q1);
      check("rnd_dout2_out", dout2_out, q2);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
